imem_loader: RTL and testbench

//   Writer side of the instruction memory. Accepts a byte stream (valid/ready) carrying a program image.

---
 rtl/imem_loader.sv | 214 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
//   Receives a program image as a byte stream (LEN_LO, LEN_HI, then 4*N data
//   bytes, least-significant byte first per word). Each assembled 32-bit word
//   is written through a synchronous write port. The CPU is held in reset while
//   a load runs and is released when the load completes.
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
//   checksum byte and the chk_err output.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                begin a load; honoured only in IDLE/DONE
//   in_valid/in_data     byte source; in_ready accepts (transfer = valid & ready)
//   mem_we/addr/wdata    instruction memory write port, one cycle per word
//   cpu_rst_n            active-low CPU reset
//   busy, done           load in progress / one-cycle completion pulse
//   words_loaded         words written this load (saturates at SIZE)
//   overflow             sticky: image longer than SIZE, cleared by start
//   chk_err              (checksum build only) sticky checksum mismatch
module imem_loader #(
  parameter int unsigned SIZE      = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_loaded,
  output logic        overflow
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic        chk_err
`endif
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_LAST, S_DONE, S_CHK} state_e;
  localparam state_e S_END = S_CHK;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_LAST, S_DONE} state_e;
  localparam state_e S_END = S_LAST;
`endif

  state_e      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic [15:0] words_q, words_d;
  logic        overflow_q, overflow_d;
  logic        xfer;
  logic [15:0] len_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic        chk_err_q, chk_err_d;
`endif

  assign in_ready = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    || (state_q == S_CHK)
`endif
                    ;
  assign xfer     = in_valid & in_ready;
  assign len_full = {in_data, len_lo_q};

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_n_d = cpu_rst_n_q;
    words_d     = words_q;
    overflow_d  = overflow_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_err_d   = chk_err_q;
`endif

    if (xfer) csum_d = csum_q ^ in_data;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_LEN0;
          cpu_rst_n_d = 1'b0;
          overflow_d  = 1'b0;
          words_d     = '0;
          idx_d       = '0;
          byte_cnt_d  = '0;
          csum_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_err_d   = 1'b0;
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_LEN0: if (xfer) begin
        len_lo_d = in_data;
        state_d  = S_LEN1;
      end
      S_LEN1: if (xfer) begin
        rem_d   = len_full;
        state_d = (len_full == 16'd0) ? S_END : S_DATA;
      end
      S_DATA: if (xfer) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    word_d[7:0]   = in_data;
          2'd1:    word_d[15:8]  = in_data;
          2'd2:    word_d[23:16] = in_data;
          default: begin
            // Write is registered here so it appears the cycle after the 4th byte.
            if (32'(idx_q) < SIZE) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
              mem_wdata_d = {in_data, word_q};
              words_d     = words_q + 16'd1;
            end else begin
              overflow_d  = 1'b1;
            end
            idx_d = idx_q + 16'd1;
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = S_END;
          end
        endcase
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (xfer) begin
        chk_err_d = (in_data != csum_q);
        state_d   = S_LAST;
      end
`endif
      // One settling cycle so DONE follows the final write strobe.
      S_LAST: begin
        state_d = S_DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
        cpu_rst_n_d = ~chk_err_q;
`else
        cpu_rst_n_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= ~BOOT_HOLD;
      words_q     <= '0;
      overflow_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      words_q     <= words_d;
      overflow_q  <= overflow_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign words_loaded = words_q;
  assign overflow     = overflow_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign chk_err      = chk_err_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int unsigned SIZE = 4;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, cpu_rst_n, busy, done, overflow;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic        chk_err;
`endif

  imem_loader #(.SIZE(SIZE), .BASE_ADDR(BASE), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .words_loaded(words_loaded),
    .overflow(overflow)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] wbuf[16];
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done === 1'b1) done_cnt++;
      if (mem_we === 1'b1) begin
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("mem_addr", mem_addr, e.addr);
          check("mem_wdata", mem_wdata, e.data);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Reference model: builds the stream and the expected writes from the word list.
  task automatic do_load(input int n, input bit gaps, input bit bad_chk, input bit zap);
    logic [7:0] bytes[$];
    logic [7:0] cs;
    int lat;
    int exp_wl;
    bit exp_rel;
    bytes.push_back(8'(n));
    bytes.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) bytes.push_back(wbuf[i][8*k +: 8]);
      if (i < int'(SIZE)) exp_q.push_back('{BASE + 32'(4 * i), wbuf[i]});
    end
    cs = '0;
    foreach (bytes[j]) cs = cs ^ bytes[j];
    exp_rel = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    bytes.push_back(bad_chk ? ~cs : cs);
    exp_rel = !bad_chk;
`endif
    exp_wl = (n < int'(SIZE)) ? n : int'(SIZE);
    done_cnt = 0;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("cpu_rst_held", 32'(cpu_rst_n), 32'd0);
    check("wl_cleared", 32'(words_loaded), 32'd0);
    check("ovf_cleared", 32'(overflow), 32'd0);
    foreach (bytes[j]) begin
      if (zap && j == bytes.size() / 2) pulse_start();
      send_byte(bytes[j], gaps);
    end
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    check("done_latency", 32'(lat), 32'd2);
    check("cpu_rst_n_end", 32'(cpu_rst_n), 32'(exp_rel));
    check("words_loaded", 32'(words_loaded), 32'(exp_wl));
    check("overflow", 32'(overflow), 32'(n > int'(SIZE)));
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("chk_err", 32'(chk_err), 32'(bad_chk));
`endif
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("words_hold", 32'(words_loaded), 32'(exp_wl));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    rst_n = 1'b1;

    // Directed single-word program: 01 00 93 00 50 00.
    wbuf[0] = 32'h0050_0093;
    do_load(1, 1'b0, 1'b0, 1'b0);

    // Three words with random valid gaps.
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    do_load(3, 1'b1, 1'b0, 1'b0);

    // Overflow: six words into a four-word memory.
    for (int i = 0; i < 6; i++) wbuf[i] = $urandom;
    do_load(6, 1'b1, 1'b0, 1'b0);

    // Empty image.
    do_load(0, 1'b0, 1'b0, 1'b0);

    // Abort mid-word via reset; the partial word must never be written.
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("abort_words", 32'(words_loaded), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_write", 32'(mem_we), 32'd0);

    // Fresh load with a stray start pulse in the middle.
    for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
    do_load(2, 1'b1, 1'b0, 1'b1);

    // Random image lengths around the memory size.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      do_load(n, 1'b1, 1'b0, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    wbuf[0] = 32'h0050_0093;
    do_load(1, 1'b0, 1'b1, 1'b0);
    do_load(1, 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
